// File: rtl/fetch_sequencer.sv
// Instruction-fetch and program-flow sequencer: fetches over a req/valid memory port,
// issues to decode over valid/ready, and redirects the PC through a writable jump LUT.
module fetch_sequencer #(
    parameter int                  PC_W       = 12,
    parameter int                  INSTR_W    = 9,
    parameter int                  JLUT_DEPTH = 32,
    parameter int                  END_PC     = 219,
    parameter logic [INSTR_W-1:0]  HALT_CODE  = {INSTR_W{1'b1}},
    localparam int                 JP_W       = $clog2(JLUT_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jen,
    input  logic               brc_j,
    input  logic [JP_W-1:0]    jptr,
    input  logic               lut_we,
    input  logic [JP_W-1:0]    lut_waddr,
    input  logic [PC_W-1:0]    lut_wdata,
    output logic [PC_W-1:0]    pc,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    localparam bit            END_EN  = (END_PC != 0);
    localparam logic [PC_W:0] END_LIM = (PC_W+1)'(END_PC);

    state_t            state;
    state_t            next_state;
    logic [PC_W-1:0]   jlut [JLUT_DEPTH];
    logic [PC_W-1:0]   npc;
    logic              handshake;
    logic              is_halt_code;
    logic              jump_taken;
    logic              past_end;

    assign handshake    = (state == ISSUE) && instr_ready;
    assign is_halt_code = (instr == HALT_CODE);
    assign jump_taken   = jen && brc_j;
    assign imem_addr    = pc;

    // The LUT read is combinational on the registered array, so a same-cycle write
    // to the entry being read is seen only on the following cycle.
    always_comb begin
        npc = pc + 1'b1;
        if (jump_taken) begin
            npc = jlut[jptr];
        end
    end

    assign past_end = END_EN && ({1'b0, npc} >= END_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = FETCH;
            FETCH: begin
                if (imem_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    if (is_halt_code || past_end) begin
                        next_state = HALT;
                    end else begin
                        next_state = FETCH;
                    end
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        done        = 1'b0;
        case (state)
            FETCH:   imem_req    = 1'b1;
            ISSUE:   instr_valid = 1'b1;
            HALT:    done        = 1'b1;
            default: ;
        endcase
    end

    // A halt instruction freezes the PC on itself; a past-end target is still committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= '0;
        end else begin
            if ((state == FETCH) && imem_valid) begin
                instr <= imem_data;
            end
            if (handshake && !is_halt_code) begin
                pc <= npc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < JLUT_DEPTH; i++) begin
                jlut[i] <= '0;
            end
        end else if (lut_we) begin
            jlut[lut_waddr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a latency-configurable memory model that returns
// the address as data, plus hand-computed PC/instruction sequences.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jen;
    logic        brc_j;
    logic [4:0]  jptr;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [11:0] lut_wdata;
    logic [11:0] pc;
    logic        done;

    int errors = 0;
    int checks = 0;
    int lat_cfg = 0;
    int halt_at = -1;
    int req_cnt;

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .jen(jen), .brc_j(brc_j), .jptr(jptr),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pc(pc), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers lat_cfg cycles after the request first rises.
    assign imem_valid = imem_req && (req_cnt >= lat_cfg);
    assign imem_data  = (int'(imem_addr) == halt_at) ? 9'h1FF : imem_addr[8:0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cnt <= 0;
        end else if (imem_req && !imem_valid) begin
            req_cnt <= req_cnt + 1;
        end else begin
            req_cnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        lut_we = 1'b0;
        jen = 1'b0;
        brc_j = 1'b0;
        jptr = '0;
        instr_ready = 1'b1;
        lat_cfg = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req", imem_req, 0);
        checkOutput("rst_ivalid", instr_valid, 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_done", done, 0);
        reset = 1'b0;
        #1;
        checkOutput("idle_req", imem_req, 0);
    endtask

    task automatic expectFetch(input int addr);
        @(negedge clk);
        checkOutput("fetch_req", imem_req, 1);
        checkOutput("fetch_addr", imem_addr, addr);
        checkOutput("fetch_ivalid", instr_valid, 0);
    endtask

    task automatic expectIssue(input int addr);
        @(negedge clk);
        checkOutput("issue_ivalid", instr_valid, 1);
        checkOutput("issue_instr", instr, addr);
        checkOutput("issue_pc", pc, addr);
    endtask

    initial begin
        reset = 1'b1;
        lut_waddr = '0;
        lut_wdata = '0;
        instr_ready = 1'b1;

        // Straight-line code, ready stall at pc=2, slow memory at pc=4, then jumps and END_PC.
        applyReset();
        expectFetch(0); expectIssue(0);
        expectFetch(1); expectIssue(1);
        expectFetch(2); expectIssue(2);
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_ivalid", instr_valid, 1);
            checkOutput("stall_instr", instr, 2);
            checkOutput("stall_pc", pc, 2);
            checkOutput("stall_req", imem_req, 0);
        end
        instr_ready = 1'b1;
        expectFetch(3); expectIssue(3);
        lat_cfg = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("slow_req", imem_req, 1);
            checkOutput("slow_addr", imem_addr, 4);
            checkOutput("slow_ivalid", instr_valid, 0);
        end
        lat_cfg = 0;
        expectIssue(4);
        instr_ready = 1'b0;
        lut_we = 1'b1; lut_waddr = 5; lut_wdata = 100;
        @(negedge clk);
        lut_we = 1'b0;
        checkOutput("lutwr_pc_hold", pc, 4);
        instr_ready = 1'b1; jen = 1'b1; brc_j = 1'b1; jptr = 5;
        expectFetch(100); expectIssue(100);
        brc_j = 1'b0;
        expectFetch(101); expectIssue(101);
        brc_j = 1'b1;
        lut_we = 1'b1; lut_waddr = 5; lut_wdata = 50;
        expectFetch(100);
        lut_we = 1'b0;
        expectIssue(100);
        expectFetch(50);
        jen = 1'b0;
        expectIssue(50);
        lut_we = 1'b1; lut_waddr = 7; lut_wdata = 218;
        expectFetch(51);
        lut_we = 1'b0;
        expectIssue(51);
        jen = 1'b1; brc_j = 1'b1; jptr = 7;
        expectFetch(218);
        jen = 1'b0;
        expectIssue(218);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("end_done", done, 1);
            checkOutput("end_pc", pc, 219);
            checkOutput("end_req", imem_req, 0);
            checkOutput("end_ivalid", instr_valid, 0);
        end

        // HALT_CODE fetched at pc=7 freezes the PC there.
        halt_at = 7;
        applyReset();
        for (int k = 0; k < 7; k++) begin
            expectFetch(k); expectIssue(k);
        end
        expectFetch(7);
        @(negedge clk);
        checkOutput("hc_ivalid", instr_valid, 1);
        checkOutput("hc_instr", instr, 9'h1FF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hc_done", done, 1);
            checkOutput("hc_pc", pc, 7);
            checkOutput("hc_req", imem_req, 0);
        end

        // Reset during ISSUE clears outputs and the LUT immediately.
        halt_at = -1;
        applyReset();
        expectFetch(0); expectIssue(0);
        expectFetch(1); expectIssue(1);
        expectFetch(2); expectIssue(2);
        instr_ready = 1'b0;
        lut_we = 1'b1; lut_waddr = 3; lut_wdata = 9;
        @(negedge clk);
        lut_we = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("mid_instr", instr, 0);
        checkOutput("mid_ivalid", instr_valid, 0);
        checkOutput("mid_req", imem_req, 0);
        checkOutput("mid_pc", pc, 0);
        checkOutput("mid_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b1;
        #1;
        checkOutput("mid_idle_req", imem_req, 0);
        expectFetch(0); expectIssue(0);
        jen = 1'b1; brc_j = 1'b1; jptr = 3;
        expectFetch(0);
        jen = 1'b0;
        expectIssue(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
